// File: rtl/hazard_detection_unit.sv
// Load-use hazard detector: stalls IF/ID and bubbles ID/EX when a load in ID
// writes a register that the instruction in IF reads.
// Latency: insert_nop is combinational, zero cycles. Backpressure: none, it is the stall source.
//
// Optional build macro: HAZARD_STATS_EN adds a saturating stall-cycle counter.
//
// Ports:
//   clk                 clock, used only by the optional counter
//   rst_n               asynchronous active-low reset; forces insert_nop low
//   opcode              opcode of the instruction in ID
//   reg_file_wr_addr    per-stage rd addresses (.ID used)
//   reg_file_rd_addr_1  per-stage rs1 addresses (.IF used)
//   reg_file_rd_addr_2  per-stage rs2 addresses (.IF used)
//   insert_nop          stall PC and IF/ID, inject bubble into ID/EX
//   hazard_count        cycles with insert_nop high (HAZARD_STATS_EN only)

package riscv_pkg;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_FENCE  = 7'b0001111,
    OP_IMM    = 7'b0010011,
    OP_AUIPC  = 7'b0010111,
    OP_STORE  = 7'b0100011,
    OP_OP     = 7'b0110011,
    OP_LUI    = 7'b0110111,
    OP_BRANCH = 7'b1100011,
    OP_JALR   = 7'b1100111,
    OP_JAL    = 7'b1101111,
    OP_SYSTEM = 7'b1110011
  } RiscvOpcodes;

  typedef struct packed {
    logic [4:0] IF;
    logic [4:0] ID;
    logic [4:0] EX;
    logic [4:0] MEM;
    logic [4:0] WB;
  } PipeLineSignal_5;

endpackage

module hazard_detection_unit
  import riscv_pkg::*;
#(
  parameter int XLEN_CNT = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  RiscvOpcodes         opcode,
  input  PipeLineSignal_5     reg_file_wr_addr,
  input  PipeLineSignal_5     reg_file_rd_addr_1,
  input  PipeLineSignal_5     reg_file_rd_addr_2,
`ifdef HAZARD_STATS_EN
  output logic [XLEN_CNT-1:0] hazard_count,
`endif
  output logic                insert_nop
);

  logic       is_load;
  logic       hazard;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;

  assign rd  = reg_file_wr_addr.ID;
  assign rs1 = reg_file_rd_addr_1.IF;
  assign rs2 = reg_file_rd_addr_2.IF;

  // An if-statement (rather than a ternary) makes an X/unknown opcode fall
  // through to the non-load branch in simulation, so the stall never asserts
  // unless the opcode really equals OP_LOAD.
  always_comb begin
    is_load = 1'b0;
    if (opcode == OP_LOAD) begin
      is_load = 1'b1;
    end
  end

  // rs2 is compared even for formats without rs2; the extra stall is safe.
  assign hazard     = is_load && (rd != 5'd0) && ((rs1 == rd) || (rs2 == rd));
  assign insert_nop = hazard && rst_n;

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hazard_count <= '0;
    end else if (insert_nop && (hazard_count != {XLEN_CNT{1'b1}})) begin
      hazard_count <= hazard_count + 1'b1;
    end
  end

  logic unused_fields;
  assign unused_fields = ^{reg_file_wr_addr.IF, reg_file_wr_addr.EX,
                           reg_file_wr_addr.MEM, reg_file_wr_addr.WB,
                           reg_file_rd_addr_1.ID, reg_file_rd_addr_1.EX,
                           reg_file_rd_addr_1.MEM, reg_file_rd_addr_1.WB,
                           reg_file_rd_addr_2.ID, reg_file_rd_addr_2.EX,
                           reg_file_rd_addr_2.MEM, reg_file_rd_addr_2.WB};
`else
  // Without the counter the clock has no load.
  logic unused_fields;
  assign unused_fields = ^{clk,
                           reg_file_wr_addr.IF, reg_file_wr_addr.EX,
                           reg_file_wr_addr.MEM, reg_file_wr_addr.WB,
                           reg_file_rd_addr_1.ID, reg_file_rd_addr_1.EX,
                           reg_file_rd_addr_1.MEM, reg_file_rd_addr_1.WB,
                           reg_file_rd_addr_2.ID, reg_file_rd_addr_2.EX,
                           reg_file_rd_addr_2.MEM, reg_file_rd_addr_2.WB};
`endif

endmodule

// File: tb/tb_hazard_detection_unit.sv
module tb_hazard_detection_unit;
  import riscv_pkg::*;

  localparam int CW = 3;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic            clk;
  logic            rst_n;
  RiscvOpcodes     opcode;
  PipeLineSignal_5 wr_addr;
  PipeLineSignal_5 rd_addr_1;
  PipeLineSignal_5 rd_addr_2;
  logic            insert_nop;
`ifdef HAZARD_STATS_EN
  logic [CW-1:0]   hazard_count;
`endif

  int vectors = 0;
  int miscompares = 0;
  int model_cnt = 0;

  hazard_detection_unit #(.XLEN_CNT(CW)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .opcode             (opcode),
    .reg_file_wr_addr   (wr_addr),
    .reg_file_rd_addr_1 (rd_addr_1),
    .reg_file_rd_addr_2 (rd_addr_2),
`ifdef HAZARD_STATS_EN
    .hazard_count       (hazard_count),
`endif
    .insert_nop         (insert_nop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: a stall is wanted exactly when the ID instruction is a load
  // whose nonzero destination is read by the IF instruction.
  function automatic logic ref_nop(input logic [6:0] op, input int rd, input int s1,
                                   input int s2, input logic rstn);
    if (!rstn) return 1'b0;
    if (op != 7'b0000011) return 1'b0;
    if (rd == 0) return 1'b0;
    return (s1 == rd) || (s2 == rd);
  endfunction

  task automatic drive(input logic [6:0] op, input int rd, input int s1, input int s2);
    opcode       = RiscvOpcodes'(op);
    wr_addr      = PipeLineSignal_5'($urandom);
    rd_addr_1    = PipeLineSignal_5'($urandom);
    rd_addr_2    = PipeLineSignal_5'($urandom);
    wr_addr.ID   = 5'(rd);
    rd_addr_1.IF = 5'(s1);
    rd_addr_2.IF = 5'(s2);
  endtask

  task automatic directed(input string tag, input logic [6:0] op, input int rd,
                          input int s1, input int s2);
    drive(op, rd, s1, s2);
    #1;
    check(tag, {31'd0, insert_nop}, {31'd0, ref_nop(op, rd, s1, s2, rst_n)});
  endtask

  logic [6:0] ops [11] = '{7'b0000011, 7'b0001111, 7'b0010011, 7'b0010111,
                          7'b0100011, 7'b0110011, 7'b0110111, 7'b1100011,
                          7'b1100111, 7'b1101111, 7'b1110011};

  initial begin
    rst_n = 1'b0;
    drive(7'b0000011, 5, 5, 5);
    #1;
    check("nop_in_reset", {31'd0, insert_nop}, 32'd0);
`ifdef HAZARD_STATS_EN
    check("cnt_reset", {29'd0, hazard_count}, 32'd0);
`endif
    rst_n = 1'b1;
    #1;
    check("nop_after_release", {31'd0, insert_nop}, 32'd1);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;

    @(negedge clk);
    directed("fence",        7'b0001111, 5, 5, 5);
    directed("store",        7'b0100011, 5, 5, 5);
    directed("alu",          7'b0110011, 5, 5, 5);
    directed("branch",       7'b1100011, 5, 5, 5);
    directed("load_nomatch", 7'b0000011, 5, 6, 7);
    directed("load_rs1",     7'b0000011, 5, 5, 7);
    directed("load_rs2",     7'b0000011, 5, 6, 5);
    directed("load_both",    7'b0000011, 5, 5, 5);
    directed("load_rd9",     7'b0000011, 9, 5, 5);
    directed("load_x0",      7'b0000011, 0, 0, 0);
    directed("load_rd31",    7'b0000011, 31, 0, 31);

`ifdef HAZARD_STATS_EN
    // Hold a hazard for three edges, then reset between edges.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    model_cnt = 0;
    @(negedge clk);
    drive(7'b0000011, 5, 5, 7);
    repeat (3) @(posedge clk);
    #1;
    check("cnt_three", {29'd0, hazard_count}, 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("cnt_async_clear", {29'd0, hazard_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("cnt_resume", {29'd0, hazard_count}, 32'd1);
    repeat (CNT_MAX + 4) @(posedge clk);
    #1;
    check("cnt_saturate", {29'd0, hazard_count}, CNT_MAX);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    model_cnt = 0;
`endif

    // Randomized run against the reference, biased to small register numbers
    // so matches and x0 cases show up often.
    for (int i = 0; i < 400; i++) begin
      logic [6:0] op;
      int rd, s1, s2;
      logic exp_nop;
      @(negedge clk);
      case ($urandom_range(0, 3))
        0:       op = 7'($urandom);
        1, 2:    op = 7'b0000011;
        default: op = ops[$urandom_range(0, 10)];
      endcase
      rd = $urandom_range(0, 3);
      s1 = $urandom_range(0, 3);
      s2 = $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) begin
        rd = $urandom_range(0, 31);
        s1 = $urandom_range(0, 31);
        s2 = $urandom_range(0, 31);
      end
      rst_n = ($urandom_range(0, 15) != 0);
      if (!rst_n) model_cnt = 0;
      drive(op, rd, s1, s2);
      exp_nop = ref_nop(op, rd, s1, s2, rst_n);
      #1;
      check("rand_nop", {31'd0, insert_nop}, {31'd0, exp_nop});
      @(posedge clk);
      if (exp_nop && model_cnt < CNT_MAX) model_cnt++;
      #1;
`ifdef HAZARD_STATS_EN
      check("rand_cnt", {29'd0, hazard_count}, model_cnt);
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
